// File: rtl/ste_avg_seq.sv
// Sequencer for the first-order IIR averager: clear, settle blanking, fast tracking and result publishing.
// Optional step detection / TRACK state is compiled in with `define STE_AVG_SEQ_STEP_DET_EN.
module ste_avg_seq #(
    parameter int DATA_W   = 16,
    parameter int SETTLE_N = 8,
    parameter int TRACK_N  = 4,
    parameter int STABLE_N = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              cfg_chg_i,
    input  logic              smp_vld_i,
    input  logic [DATA_W-1:0] smp_i,
    input  logic [DATA_W-1:0] avg_i,
    input  logic [DATA_W-1:0] step_thr_i,
    output logic              avg_clr_o,
    output logic              avg_en_o,
    output logic [DATA_W-1:0] result_o,
    output logic              result_vld_o,
    output logic              stable_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        SETTLE  = 3'd2,
        AVERAGE = 3'd3,
        TRACK   = 3'd4
    } state_e;

    // One counter serves SETTLE, TRACK and AVERAGE, so it is sized for the largest limit.
    localparam int CNT_MAX_01 = (SETTLE_N > TRACK_N) ? SETTLE_N : TRACK_N;
    localparam int CNT_MAX    = (CNT_MAX_01 > STABLE_N) ? CNT_MAX_01 : STABLE_N;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE_N);
    localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(STABLE_N);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                vld_dly_q, vld_dly_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                result_vld_q, result_vld_d;
    logic                avg_clr_q, avg_clr_d;
    logic                avg_en_q, avg_en_d;
    logic                stable_q, stable_d;
    logic                prio_evt;

    assign cnt_inc  = (cnt_q == CNT_MAX_C) ? cnt_q : cnt_q + CNT_W'(1);
    assign prio_evt = !enable_i || (cfg_chg_i && (state_q != IDLE));

`ifdef STE_AVG_SEQ_STEP_DET_EN
    localparam logic [CNT_W-1:0] TRACK_C = CNT_W'(TRACK_N);

    logic [DATA_W:0] diff;
    logic            step;

    // Absolute difference kept one bit wider so it can never wrap.
    assign diff = (smp_i >= avg_i) ? ({1'b0, smp_i} - {1'b0, avg_i})
                                   : ({1'b0, avg_i} - {1'b0, smp_i});
    assign step = diff > {1'b0, step_thr_i};
`else
    logic unused_step_inputs;
    assign unused_step_inputs = ^{smp_i, step_thr_i};
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        cnt_d        = cnt_q;
        vld_dly_d    = 1'b0;
        result_d     = result_q;
        result_vld_d = 1'b0;

        // A pending result is published one cycle after its sample unless a disable/reconfigure hits.
        if (vld_dly_q && !prio_evt) begin
            result_vld_d = 1'b1;
            result_d     = avg_i;
        end

        if (!enable_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (cfg_chg_i && (state_q != IDLE)) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
                CLEAR: begin
                    cnt_d   = '0;
                    state_d = (SETTLE_N == 0) ? AVERAGE : SETTLE;
                end
                SETTLE: begin
                    if (smp_vld_i) begin
                        if (cnt_inc >= SETTLE_C) begin
                            state_d = AVERAGE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                AVERAGE: begin
                    if (smp_vld_i) begin
                        vld_dly_d = 1'b1;
`ifdef STE_AVG_SEQ_STEP_DET_EN
                        if (step) begin
                            state_d = TRACK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
`else
                        cnt_d = cnt_inc;
`endif
                    end
                end
`ifdef STE_AVG_SEQ_STEP_DET_EN
                TRACK: begin
                    if (smp_vld_i) begin
                        vld_dly_d = 1'b1;
                        if (step) begin
                            cnt_d = '0;
                        end else if (cnt_inc >= TRACK_C) begin
                            state_d = AVERAGE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they line up with state_o after the edge.
        avg_clr_d = (state_d == IDLE) || (state_d == CLEAR);
        avg_en_d  = (state_d == AVERAGE);
        stable_d  = (state_d == AVERAGE) && (cnt_d >= STABLE_C);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            vld_dly_q    <= 1'b0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
            avg_clr_q    <= 1'b1;
            avg_en_q     <= 1'b0;
            stable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vld_dly_q    <= vld_dly_d;
            result_q     <= result_d;
            result_vld_q <= result_vld_d;
            avg_clr_q    <= avg_clr_d;
            avg_en_q     <= avg_en_d;
            stable_q     <= stable_d;
        end
    end

    assign avg_clr_o    = avg_clr_q;
    assign avg_en_o     = avg_en_q;
    assign result_o     = result_q;
    assign result_vld_o = result_vld_q;
    assign stable_o     = stable_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_ste_avg_seq.sv
// Self-checking bench for ste_avg_seq: randomized samples checked against expectations derived from the sequencing rules.
// A second instance with SETTLE_N=0 covers the direct CLEAR -> AVERAGE path.
module tb_ste_avg_seq;

    localparam int DATA_W   = 16;
    localparam int SETTLE_N = 8;
    localparam int TRACK_N  = 4;
    localparam int STABLE_N = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable_i;
    logic              cfg_chg_i;
    logic              smp_vld_i;
    logic [DATA_W-1:0] smp_i;
    logic [DATA_W-1:0] avg_i;
    logic [DATA_W-1:0] step_thr_i;

    logic              avg_clr_o, avg_en_o, result_vld_o, stable_o;
    logic [DATA_W-1:0] result_o;
    logic [2:0]        state_o;

    logic              z_avg_clr_o, z_avg_en_o, z_result_vld_o, z_stable_o;
    logic [DATA_W-1:0] z_result_o;
    logic [2:0]        z_state_o;

    int                n_tests = 0;
    int                n_fail  = 0;
    logic [DATA_W-1:0] last_res;

    ste_avg_seq #(.DATA_W(DATA_W), .SETTLE_N(SETTLE_N), .TRACK_N(TRACK_N), .STABLE_N(STABLE_N)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .cfg_chg_i(cfg_chg_i),
        .smp_vld_i(smp_vld_i), .smp_i(smp_i), .avg_i(avg_i), .step_thr_i(step_thr_i),
        .avg_clr_o(avg_clr_o), .avg_en_o(avg_en_o), .result_o(result_o),
        .result_vld_o(result_vld_o), .stable_o(stable_o), .state_o(state_o)
    );

    ste_avg_seq #(.DATA_W(DATA_W), .SETTLE_N(0), .TRACK_N(TRACK_N), .STABLE_N(STABLE_N)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .cfg_chg_i(cfg_chg_i),
        .smp_vld_i(smp_vld_i), .smp_i(smp_i), .avg_i(avg_i), .step_thr_i(step_thr_i),
        .avg_clr_o(z_avg_clr_o), .avg_en_o(z_avg_en_o), .result_o(z_result_o),
        .result_vld_o(z_result_vld_o), .stable_o(z_stable_o), .state_o(z_state_o)
    );

    always #5 clk = ~clk;

    // One clock: inputs applied now, outputs observed 1 time unit after the edge that consumed them.
    task automatic cyc(input logic v, input logic [DATA_W-1:0] s, input logic [DATA_W-1:0] a);
        smp_vld_i = v;
        smp_i     = s;
        avg_i     = a;
        @(posedge clk);
        #1;
        smp_vld_i = 1'b0;
        cfg_chg_i = 1'b0;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, DATA_W'($urandom), DATA_W'($urandom));
    endtask

    // Cycle after a strobe: a published result must carry the averager value present in this cycle.
    task automatic follow(input logic exp_vld, input string name);
        logic [DATA_W-1:0] a;
        a = DATA_W'($urandom);
        cyc(1'b0, DATA_W'($urandom), a);
        n_tests++;
        if (result_vld_o !== exp_vld) begin
            n_fail++;
            $display("FAIL %s result_vld: got %b expected %b", name, result_vld_o, exp_vld);
        end
        if (exp_vld) begin
            n_tests++;
            if (result_o !== a) begin
                n_fail++;
                $display("FAIL %s result_o: got %0d expected %0d", name, result_o, a);
            end
            last_res = a;
        end
    endtask

    task automatic check_ctl(input logic [2:0] st, input logic clr, input logic en, input logic stb,
                             input string name);
        n_tests++;
        if ({state_o, avg_clr_o, avg_en_o, stable_o} !== {st, clr, en, stb}) begin
            n_fail++;
            $display("FAIL %s: got state=%0d clr=%b en=%b stable=%b expected state=%0d clr=%b en=%b stable=%b",
                     name, state_o, avg_clr_o, avg_en_o, stable_o, st, clr, en, stb);
        end
    endtask

    task automatic start_run();
        rst_n      = 1'b0;
        enable_i   = 1'b0;
        cfg_chg_i  = 1'b0;
        step_thr_i = '1;
        repeat (2) idle_cyc();
        rst_n    = 1'b1;
        enable_i = 1'b1;
        idle_cyc();
        idle_cyc();
        last_res = '0;
    endtask

    task automatic reach_average();
        start_run();
        repeat (SETTLE_N) cyc(1'b1, DATA_W'($urandom), DATA_W'($urandom));
        check_ctl(3'd3, 1'b0, 1'b1, 1'b0, "reach_average");
    endtask

    // Sample within +/-max_d of a random averager value.
    task automatic near_pair(input int max_d, output logic [DATA_W-1:0] s, output logic [DATA_W-1:0] a);
        int av, d;
        av = $urandom_range(200, 60000);
        d  = $urandom_range(0, max_d);
        a  = DATA_W'(av);
        s  = ($urandom % 2 == 0) ? DATA_W'(av + d) : DATA_W'(av - d);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        enable_i   = 1'b1;
        cfg_chg_i  = 1'b0;
        step_thr_i = '1;
        repeat (3) idle_cyc();
        check_ctl(3'd0, 1'b1, 1'b0, 1'b0, "reset_ctl");
        n_tests++;
        if ({result_vld_o, result_o} !== {1'b0, {DATA_W{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_result: got vld=%b res=%0d expected vld=0 res=0", result_vld_o, result_o);
        end
        rst_n = 1'b1;
        idle_cyc();
        check_ctl(3'd1, 1'b1, 1'b0, 1'b0, "reset_release_clear");
        idle_cyc();
        check_ctl(3'd2, 1'b0, 1'b0, 1'b0, "reset_clear_one_cycle");
    endtask

    task automatic test_settle();
        start_run();
        for (int k = 1; k <= SETTLE_N + STABLE_N + 1; k++) begin
            cyc(1'b1, DATA_W'($urandom), DATA_W'($urandom));
            check_ctl((k < SETTLE_N) ? 3'd2 : 3'd3, 1'b0, (k >= SETTLE_N),
                      ((k - SETTLE_N) >= STABLE_N), $sformatf("settle_ctl_%0d", k));
            follow(k > SETTLE_N, $sformatf("settle_res_%0d", k));
            repeat ($urandom_range(0, 2)) begin
                idle_cyc();
                n_tests++;
                if (result_vld_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL settle_gap_%0d: got result_vld=%b expected 0", k, result_vld_o);
                end
            end
        end
    endtask

`ifdef STE_AVG_SEQ_STEP_DET_EN
    task automatic test_step();
        logic [DATA_W-1:0] s, a;
        reach_average();
        step_thr_i = 16'd100;
        for (int i = 0; i < 6; i++) begin
            near_pair(100, s, a);
            if (i == 0) s = a + 16'd100;
            if (i == 1) s = a - 16'd100;
            cyc(1'b1, s, a);
            check_ctl(3'd3, 1'b0, 1'b1, 1'b0, $sformatf("step_quiet_%0d", i));
            follow(1'b1, "step_quiet_res");
        end
        cyc(1'b1, 16'd1200, 16'd1000);
        check_ctl(3'd4, 1'b0, 1'b0, 1'b0, "step_enter_track");
        follow(1'b1, "step_sample_res");
        for (int i = 0; i < TRACK_N - 1; i++) begin
            near_pair(100, s, a);
            if (i == 0) s = a + 16'd100;
            cyc(1'b1, s, a);
            check_ctl(3'd4, 1'b0, 1'b0, 1'b0, $sformatf("track_partial_%0d", i));
            follow(1'b1, "track_res");
        end
        near_pair(0, s, a);
        cyc(1'b1, a - 16'd101, a);
        check_ctl(3'd4, 1'b0, 1'b0, 1'b0, "track_restart");
        for (int i = 1; i <= TRACK_N; i++) begin
            near_pair(100, s, a);
            cyc(1'b1, s, a);
            check_ctl((i == TRACK_N) ? 3'd3 : 3'd4, 1'b0, (i == TRACK_N), 1'b0,
                      $sformatf("track_exit_%0d", i));
            follow(1'b1, "track_exit_res");
        end
    endtask
`else
    task automatic test_no_step();
        reach_average();
        step_thr_i = '0;
        cyc(1'b1, '1, '0);
        check_ctl(3'd3, 1'b0, 1'b1, 1'b0, "nostep_max_pos");
        follow(1'b1, "nostep_res_a");
        cyc(1'b1, '0, '1);
        check_ctl(3'd3, 1'b0, 1'b1, 1'b0, "nostep_max_neg");
        follow(1'b1, "nostep_res_b");
    endtask
`endif

    task automatic test_range_change();
        reach_average();
        repeat (STABLE_N) cyc(1'b1, DATA_W'($urandom), DATA_W'($urandom));
        check_ctl(3'd3, 1'b0, 1'b1, 1'b1, "range_stable_before");
        cfg_chg_i = 1'b1;
        cyc(1'b1, DATA_W'($urandom), DATA_W'($urandom));
        check_ctl(3'd1, 1'b1, 1'b0, 1'b0, "range_to_clear");
        n_tests++;
        if (result_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL range_cancel_pending: got result_vld=%b expected 0", result_vld_o);
        end
        follow(1'b0, "range_dropped_sample");
        check_ctl(3'd2, 1'b0, 1'b0, 1'b0, "range_to_settle");
    endtask

    task automatic test_disable();
        reach_average();
        cyc(1'b1, DATA_W'($urandom), DATA_W'($urandom));
        follow(1'b1, "disable_prior_res");
        cyc(1'b1, DATA_W'($urandom), DATA_W'($urandom));
        enable_i = 1'b0;
        idle_cyc();
        check_ctl(3'd0, 1'b1, 1'b0, 1'b0, "disable_from_average");
        n_tests++;
        if ({result_vld_o, result_o} !== {1'b0, last_res}) begin
            n_fail++;
            $display("FAIL disable_cancel_hold: got vld=%b res=%0d expected vld=0 res=%0d",
                     result_vld_o, result_o, last_res);
        end
        cfg_chg_i = 1'b1;
        idle_cyc();
        check_ctl(3'd0, 1'b1, 1'b0, 1'b0, "cfg_in_idle");
        enable_i = 1'b1;
        idle_cyc();
        check_ctl(3'd1, 1'b1, 1'b0, 1'b0, "reenable_clear");
        idle_cyc();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, DATA_W'($urandom), DATA_W'($urandom));
            follow(1'b0, "settle_no_result");
        end
        enable_i = 1'b0;
        idle_cyc();
        check_ctl(3'd0, 1'b1, 1'b0, 1'b0, "disable_mid_settle");
        n_tests++;
        if (result_o !== last_res) begin
            n_fail++;
            $display("FAIL disable_result_hold: got %0d expected %0d", result_o, last_res);
        end
        enable_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] a;
        int                pulses;
        reach_average();
        pulses = 0;
        for (int c = 0; c <= 101; c++) begin
            a = DATA_W'($urandom);
            cyc(c < 100, DATA_W'($urandom), a);
            if (result_vld_o === 1'b1) pulses++;
            n_tests++;
            if ({result_vld_o, (result_vld_o ? result_o : a)} !== {(c >= 1 && c <= 100), a}) begin
                n_fail++;
                $display("FAIL b2b_cycle_%0d: got vld=%b res=%0d expected vld=%b res=%0d",
                         c, result_vld_o, result_o, (c >= 1 && c <= 100), a);
            end
        end
        n_tests++;
        if (pulses != 100) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d expected 100", pulses);
        end
    endtask

    task automatic test_settle_zero();
        logic [DATA_W-1:0] a;
        rst_n      = 1'b0;
        enable_i   = 1'b0;
        step_thr_i = '1;
        repeat (2) idle_cyc();
        rst_n    = 1'b1;
        enable_i = 1'b1;
        idle_cyc();
        n_tests++;
        if ({z_state_o, z_avg_clr_o} !== {3'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_clear: got state=%0d clr=%b expected state=1 clr=1", z_state_o, z_avg_clr_o);
        end
        idle_cyc();
        n_tests++;
        if ({z_state_o, z_avg_clr_o, z_avg_en_o, z_stable_o} !== {3'd3, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL zero_direct_average: got state=%0d clr=%b en=%b stable=%b expected 3/0/1/0",
                     z_state_o, z_avg_clr_o, z_avg_en_o, z_stable_o);
        end
        cyc(1'b1, DATA_W'($urandom), DATA_W'($urandom));
        a = DATA_W'($urandom);
        cyc(1'b0, DATA_W'($urandom), a);
        n_tests++;
        if ({z_result_vld_o, z_result_o} !== {1'b1, a}) begin
            n_fail++;
            $display("FAIL zero_first_result: got vld=%b res=%0d expected vld=1 res=%0d",
                     z_result_vld_o, z_result_o, a);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        enable_i   = 1'b0;
        cfg_chg_i  = 1'b0;
        smp_vld_i  = 1'b0;
        smp_i      = '0;
        avg_i      = '0;
        step_thr_i = '1;
        last_res   = '0;
        #2;
        test_reset();
        test_settle();
`ifdef STE_AVG_SEQ_STEP_DET_EN
        test_step();
`else
        test_no_step();
`endif
        test_range_change();
        test_disable();
        test_back_to_back();
        test_settle_zero();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ste_avg_seq.md
Name: ste_avg_seq

Overview:
- Sequencer for the first-order IIR averager in the multimeter datapath.
- Drives the averager's clear and enable controls:
  - clears it on start and on range/mode change;
  - blanks samples during analog settling;
  - bypasses averaging after a large input step (fast tracking);
  - re-enables averaging once the input is steady.
- Publishes averaged results with a valid strobe and a "stable" flag to the display/format logic.

Parameters:
- DATA_W, 16, sample and average width (unsigned)
- SETTLE_N, 8, valid samples discarded after clear (0 allowed)
- TRACK_N, 4, consecutive step-free samples required to leave TRACK
- STABLE_N, 32, consecutive AVERAGE samples before stable_o rises (>=1)

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, reset; synchronous, active-low
- enable_i, input, 1, measurement run (level)
- cfg_chg_i, input, 1, range/mode changed (1-cycle pulse)
- smp_vld_i, input, 1, new ADC sample strobe
- smp_i, input, DATA_W, raw ADC sample
- avg_i, input, DATA_W, averager output (dout_o)
- step_thr_i, input, DATA_W, step detection threshold
- avg_clr_o, output, 1, averager clear
- avg_en_o, output, 1, averager enable (0 = bypass)
- result_o, output, DATA_W, published average
- result_vld_o, output, 1, result strobe (1 cycle)
- stable_o, output, 1, result settled
- state_o, output, 3, FSM state code

Behaviour:
- Single clock domain. rst_n is sampled on the clk edge only: synchronous, active-low.
- Reset values:
  - state IDLE; all counters 0.
  - avg_clr_o=1, avg_en_o=0.
  - result_o=0, result_vld_o=0, stable_o=0, state_o=0.
- All outputs are registered.
- States (state_o code):
  - IDLE(0): avg_clr_o=1, avg_en_o=0. Exits to CLEAR when enable_i=1.
  - CLEAR(1): avg_clr_o=1 for exactly 1 cycle; counter cleared. Goes to SETTLE, or to AVERAGE if SETTLE_N=0.
  - SETTLE(2): avg_en_o=0, no results. Counts smp_vld_i; on the SETTLE_N-th valid sample, goes to AVERAGE.
  - AVERAGE(3): avg_en_o=1. Counts valid samples (saturating). stable_o=1 once the count reaches STABLE_N.
  - TRACK(4): avg_en_o=0, stable_o=0. Goes to AVERAGE after TRACK_N consecutive step-free valid samples. A step during TRACK restarts the count.
- Transition priority, highest first:
  1. rst_n=0
  2. enable_i=0 → IDLE, from any state
  3. cfg_chg_i=1 → CLEAR, from any state except IDLE (ignored in IDLE)
  4. normal transitions
- If smp_vld_i coincides with a priority-2 or priority-3 event, the sample is dropped: no count, no result.
- Step detection (AVERAGE and TRACK only, evaluated on smp_vld_i):
  - diff = |smp_i - avg_i|, computed DATA_W+1 bits wide, no wrap.
  - step = diff > step_thr_i, strict comparison.
  - step_thr_i = all-ones never triggers; step_thr_i = 0 triggers on any nonzero diff.
- A step in AVERAGE → TRACK on the next cycle; the stable count resets to 0 and stable_o drops.
- Result path:
  - smp_vld_i accepted in AVERAGE or TRACK is delayed 1 cycle (vld_d), letting the registered averager update.
  - When vld_d=1: result_o <= avg_i and result_vld_o=1 for one cycle.
  - Latency: smp_vld_i at cycle t → result_vld_o at t+2.
  - vld_d is cancelled by priority-2 or priority-3 events.
- result_o holds its last value in IDLE, CLEAR and SETTLE. It is cleared to 0 only by reset.
- stable_o=0 in every state except AVERAGE. On entry to AVERAGE it starts at 0.
- Back-to-back smp_vld_i (every cycle) is supported without loss.
- Counters are $clog2(max+1) wide and saturate; they never wrap.

Optional Feature:
- Macro: STE_AVG_SEQ_STEP_DET_EN.
- Defined:
  - step detection and the TRACK state are present, as described above.
  - step_thr_i is used.
- Undefined:
  - no comparator; TRACK is unreachable and removed.
  - step_thr_i is ignored.
  - AVERAGE is left only by priority-2 or priority-3 events.
  - state code 4 never appears.

Test Plan:
- Reset: rst_n=0 for 3 cycles while enable_i=1 → state_o=0, avg_clr_o=1, result_vld_o=0. Release rst_n → CLEAR (state_o=1) one cycle later, avg_clr_o=1 for 1 cycle.
- Settle: SETTLE_N=8, one smp_vld_i every 4 cycles → no result_vld_o for the first 8 samples. The 9th sample gives result_vld_o 2 cycles after its strobe, with result_o=avg_i. stable_o rises after 32 AVERAGE samples.
- Step (feature on): step_thr_i=100, avg_i=1000, smp_i=1200 → TRACK, avg_en_o=0, stable_o=0. Then 4 samples with diff ≤100 → AVERAGE. diff=100 exactly does not trigger.
- Range change: cfg_chg_i pulse in AVERAGE coinciding with smp_vld_i → CLEAR next cycle, avg_clr_o=1, no result_vld_o for that sample, stable_o=0.
- Disable: enable_i=0 mid-SETTLE → IDLE next cycle, avg_en_o=0, result_o holds. cfg_chg_i pulse in IDLE → no state change.
- Corners: SETTLE_N=0 → CLEAR→AVERAGE directly. smp_vld_i every cycle for 100 cycles in AVERAGE → 100 result_vld_o pulses. Feature off, smp_i−avg_i=max → stays AVERAGE.
